if_fetch_queue: RTL and testbench

Instruction-fetch front end feeding the IF/ID pipeline register. Issues in-order sequential fetch requests to a pipelined, handshaked instruction memory and buffers returned words with their PC+4 in a small FIFO. Presents one instruction per cycle downstream, holds it under stall, and flushes and restarts on a branch/jump/jr redirect, discarding stale in-flight responses.

---
 rtl/if_fetch_queue.sv | 132 +++++++++++++
 tb/tb_if_fetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues sequential fetches to a pipelined, handshaked
// instruction memory, buffers returned words with their PC+4 and presents one
// instruction per cycle downstream. A redirect flushes the queue, restarts
// fetch and marks outstanding responses for discard.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pcplusfour
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OutW-1:0] inflight_q, inflight_d;
  logic [OutW-1:0] drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [DEPTH];

  logic [31:0] out_sum;
  logic [31:0] credit_sum;
  logic        grant;
  logic        resp_ok;
  logic        keep;
  logic        push;
  logic        pop;
  logic [63:0] head;

  // Request credit, handshake and FIFO push/pop decode.
  always_comb begin
    out_sum    = 32'(inflight_q) + 32'(drop_q);
    credit_sum = 32'(count_q) + 32'(inflight_q);
    imem_req   = !redirect && (out_sum < MAX_OUT) && (credit_sum < DEPTH);
    imem_addr  = fetch_pc_q;
    grant      = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok    = imem_rvalid && (out_sum != 32'd0);
    keep       = resp_ok && (drop_q == '0);
    push       = keep && !redirect;
    out_valid  = (count_q != '0);
    pop        = out_valid && !stall && !redirect;
    head       = mem_q[rd_ptr_q];
    out_inst       = out_valid ? head[63:32] : 32'h0;
    out_pcplusfour = out_valid ? head[31:0]  : 32'h0;
  end

  // Next-state for fetch/response PCs, outstanding counters and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Everything still outstanding becomes stale, minus a response retiring now.
      drop_d     = drop_q + inflight_q - OutW'(resp_ok);
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_ok && !keep) begin
        drop_d = drop_q - OutW'(1);
      end
      if (keep) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      inflight_d = inflight_q + OutW'(grant) - OutW'(keep);
      count_d    = count_q + CntW'(push) - CntW'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; entries are only visible once count covers them.
  always_ff @(posedge Clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= {imem_rdata, resp_pc_q + 32'd4};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: an in-order memory model with random
// grant and latency drives the DUT, and a queue-based reference model of the
// fetch queue predicts every output each cycle.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NPhase   = 6;
  localparam int          NCyc     = 400;

  logic        Clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pcplusfour;

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk            (Clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pcplusfour (out_pcplusfour)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference model state.
  logic [31:0] m_fetch_pc;
  logic [31:0] m_resp_pc;
  int          m_inflight;
  int          m_drop;
  logic [63:0] m_q[$];
  bit          model_ok;

  // Memory model: granted addresses and the earliest cycle each may respond.
  logic [31:0] pend_addr[$];
  int          pend_ready[$];
  int          cycle;

  // Per-phase probabilities (percent, reset in per mille) and max latency.
  int p_gnt   [NPhase] = '{90, 30,  0, 80, 90, 70};
  int p_rv    [NPhase] = '{100, 60, 80, 100, 70, 90};
  int p_stall [NPhase] = '{0, 70, 20, 10, 40, 30};
  int p_redir [NPhase] = '{0, 2, 3, 15, 5, 30};
  int p_rst   [NPhase] = '{0, 3, 0, 0, 10, 5};
  int lat_hi  [NPhase] = '{1, 3, 2, 1, 3, 2};

  logic        exp_req;
  logic        exp_valid;
  logic [63:0] exp_head;
  bit          do_pop;

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    model_ok    = 1'b0;
    cycle       = 0;
    m_fetch_pc  = RESET_PC;
    m_resp_pc   = RESET_PC;
    m_inflight  = 0;
    m_drop      = 0;

    for (int ph = 0; ph < NPhase; ph++) begin
      for (int c = 0; c < NCyc; c++) begin
        @(negedge Clk);
        reset    = !((ph == 0 && c < 3) || ($urandom_range(0, 999) < p_rst[ph]));
        redirect = ($urandom_range(0, 99) < p_redir[ph]);
        if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF8;
        else                           redirect_pc = $urandom() & 32'h0000_FFFC;
        stall    = ($urandom_range(0, 99) < p_stall[ph]);
        imem_gnt = ($urandom_range(0, 99) < p_gnt[ph]);
        if (reset && pend_addr.size() > 0 && pend_ready[0] <= cycle &&
            $urandom_range(0, 99) < p_rv[ph]) begin
          imem_rvalid = 1'b1;
          imem_rdata  = inst_of(pend_addr[0]);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom();
        end
        #1;

        exp_req   = !redirect && (m_inflight + m_drop < MAX_OUT) &&
                    (m_q.size() + m_inflight < DEPTH);
        exp_valid = (m_q.size() > 0);
        exp_head  = exp_valid ? m_q[0] : 64'h0;
        if (model_ok) begin
          check_eq("imem_req",       {31'b0, imem_req},  {31'b0, exp_req});
          check_eq("imem_addr",      imem_addr,          m_fetch_pc);
          check_eq("out_valid",      {31'b0, out_valid}, {31'b0, exp_valid});
          check_eq("out_inst",       out_inst,           exp_head[63:32]);
          check_eq("out_pcplusfour", out_pcplusfour,     exp_head[31:0]);
        end

        if (!reset) begin
          // Memory is reset alongside the queue.
          pend_addr.delete();
          pend_ready.delete();
          m_fetch_pc = RESET_PC;
          m_resp_pc  = RESET_PC;
          m_inflight = 0;
          m_drop     = 0;
          m_q.delete();
          model_ok   = 1'b1;
        end else begin
          if (imem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_ready.pop_front());
          end
          if (exp_req && imem_gnt) begin
            pend_addr.push_back(m_fetch_pc);
            pend_ready.push_back(cycle + $urandom_range(1, lat_hi[ph]));
          end
          if (redirect) begin
            m_q.delete();
            m_fetch_pc = redirect_pc;
            m_resp_pc  = redirect_pc;
            m_drop     = m_drop + m_inflight - (imem_rvalid ? 1 : 0);
            m_inflight = 0;
          end else begin
            do_pop = exp_valid && !stall;
            if (exp_req && imem_gnt) begin
              m_fetch_pc = m_fetch_pc + 32'd4;
              m_inflight++;
            end
            if (do_pop) void'(m_q.pop_front());
            if (imem_rvalid) begin
              if (m_drop > 0) begin
                m_drop--;
              end else begin
                m_inflight--;
                m_q.push_back({imem_rdata, m_resp_pc + 32'd4});
                m_resp_pc = m_resp_pc + 32'd4;
              end
            end
          end
        end
        cycle++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
